// File: rtl/if_stage_pkg.sv
// Shared fetch-stage types and defaults: FSM state encoding, reset vector, NOP word.
package if_stage_pkg;

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_SKID = 2'd2,
    ST_DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT    = 32'h0000_0013;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry holding register for a fetched word that decode could not take yet.
module fetch_skid (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output logic [31:0] skid_instr,
  output logic [31:0] skid_pc,
  output logic        skid_valid
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skid_instr <= '0;
      skid_pc    <= '0;
      skid_valid <= 1'b0;
    end else if (clear) begin
      skid_valid <= 1'b0;
    end else if (load) begin
      skid_instr <= instr;
      skid_pc    <= pc;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: single-outstanding request FSM, PC, IF/ID register, skid buffer.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter logic [31:0] NOP_INSTR    = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] ir,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4,
  output logic        if_valid
);

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  logic         accept;
  logic         deliver_mem, deliver_skid, skid_load, skid_clear, pc_step;
  logic [31:0]  skid_instr, skid_pc;
  logic         skid_valid;

  assign accept    = !stall || !if_valid;
  assign imem_addr = pc;
  assign if_pc4    = if_pc + 32'd4;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_REQ;
    else     state <= state_next;
  end

  // A response coinciding with a redirect retires the outstanding request, so no DROP is needed.
  always_comb begin
    state_next = state;
    if (redirect) begin
      unique case (state)
        ST_REQ:  state_next = imem_rdy ? ST_DROP : ST_REQ;
        ST_WAIT: state_next = imem_rvalid ? ST_REQ : ST_DROP;
        ST_DROP: state_next = imem_rvalid ? ST_REQ : ST_DROP;
        default: state_next = ST_REQ;
      endcase
    end else begin
      unique case (state)
        ST_REQ:  if (imem_rdy) state_next = ST_WAIT;
        ST_WAIT: if (imem_rvalid) state_next = accept ? ST_REQ : ST_SKID;
        ST_SKID: if (accept) state_next = ST_REQ;
        ST_DROP: if (imem_rvalid) state_next = ST_REQ;
        default: state_next = ST_REQ;
      endcase
    end
  end

  always_comb begin
    imem_req     = (state == ST_REQ) && !rst;
    pc_step      = (state == ST_WAIT) && imem_rvalid && !redirect;
    deliver_mem  = pc_step && accept;
    skid_load    = pc_step && !accept;
    deliver_skid = (state == ST_SKID) && accept && !redirect && skid_valid;
    skid_clear   = redirect || deliver_skid;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           pc <= RESET_VECTOR;
    else if (redirect) pc <= word_align(redirect_pc);
    else if (pc_step)  pc <= pc + 32'd4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir       <= NOP_INSTR;
      if_pc    <= RESET_VECTOR;
      if_valid <= 1'b0;
    end else if (redirect) begin
      ir       <= NOP_INSTR;
      if_valid <= 1'b0;
    end else if (deliver_mem) begin
      ir       <= imem_rdata;
      if_pc    <= pc;
      if_valid <= 1'b1;
    end else if (deliver_skid) begin
      ir       <= skid_instr;
      if_pc    <= skid_pc;
      if_valid <= 1'b1;
    end else if (accept) begin
      if_valid <= 1'b0;
    end
  end

  fetch_skid u_skid (
    .clk        (clk),
    .rst        (rst),
    .load       (skid_load),
    .clear      (skid_clear),
    .instr      (imem_rdata),
    .pc         (pc),
    .skid_instr (skid_instr),
    .skid_pc    (skid_pc),
    .skid_valid (skid_valid)
  );

endmodule

// File: tb/tb_if_stage.sv
// Directed per-cycle vector bench for if_stage plus hand-written reset corner cases.
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] ir;
  logic [31:0] if_pc;
  logic [31:0] if_pc4;
  logic        if_valid;

  int checks = 0;
  int errors = 0;

  if_stage dut (
    .clk         (clk),
    .rst         (rst),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdy    (imem_rdy),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ir          (ir),
    .if_pc       (if_pc),
    .if_pc4      (if_pc4),
    .if_valid    (if_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy;
    logic        rvalid;
    logic [31:0] rdata;
    logic        stall;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_vld;
    logic [31:0] e_ir;
    logic [31:0] e_pc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rd,
                              input logic st, input logic rr, input logic [31:0] rp,
                              input logic er, input logic [31:0] ea, input logic ev,
                              input logic [31:0] ei, input logic [31:0] ep);
    vec_t v;
    v.rdy = rdy; v.rvalid = rv; v.rdata = rd; v.stall = st; v.redir = rr; v.rpc = rp;
    v.e_req = er; v.e_addr = ea; v.e_vld = ev; v.e_ir = ei; v.e_pc = ep;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic er, input logic [31:0] ea,
                           input logic ev, input logic [31:0] ei, input logic [31:0] ep);
    logic [31:0] ep4;
    ep4 = ep + 32'd4;
    check({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, er});
    check({tag, " imem_addr"}, imem_addr, ea);
    check({tag, " if_valid"}, {31'd0, if_valid}, {31'd0, ev});
    check({tag, " ir"}, ir, ei);
    check({tag, " if_pc"}, if_pc, ep);
    check({tag, " if_pc4"}, if_pc4, ep4);
  endtask

  task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                       input logic st, input logic rr, input logic [31:0] rp);
    imem_rdy = rdy; imem_rvalid = rv; imem_rdata = rd;
    stall = st; redirect = rr; redirect_pc = rp;
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    //          rdy rv rdata          st rr rpc            req addr          vld ir             if_pc
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        0, NOP,           32'h0));        // 0
    vecs.push_back(mk(1, 1, 32'h00100093, 0, 0, 32'h0,        0, 32'h0,        0, NOP,           32'h0));        // 1
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h4,        1, 32'h00100093,  32'h0));        // 2
    vecs.push_back(mk(1, 1, 32'h00200113, 0, 0, 32'h0,        0, 32'h4,        0, 32'h00100093,  32'h0));        // 3
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h8,        1, 32'h00200113,  32'h4));        // 4
    vecs.push_back(mk(1, 1, 32'h00300193, 0, 0, 32'h0,        0, 32'h8,        0, 32'h00200113,  32'h4));        // 5
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'hC,        1, 32'h00300193,  32'h8));        // 6 stall
    vecs.push_back(mk(1, 1, 32'h00500093, 1, 0, 32'h0,        0, 32'hC,        1, 32'h00300193,  32'h8));        // 7 -> SKID
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        0, 32'h10,       1, 32'h00300193,  32'h8));        // 8 SKID held
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h10,       1, 32'h00300193,  32'h8));        // 9 release
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h10,       1, 32'h00500093,  32'hC));        // 10
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h10,       0, 32'h00500093,  32'hC));        // 11
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'h102,      0, 32'h10,       0, 32'h00500093,  32'hC));        // 12 redirect in WAIT
    vecs.push_back(mk(0, 1, 32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h100,      0, NOP,           32'hC));        // 13 DROP stale
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'h100,      0, NOP,           32'hC));        // 14
    vecs.push_back(mk(0, 1, 32'h11111111, 1, 1, 32'h200,      0, 32'h100,      0, NOP,           32'hC));        // 15 redirect+rvalid+stall
    vecs.push_back(mk(1, 0, 32'h0,        1, 0, 32'h0,        1, 32'h200,      0, NOP,           32'hC));        // 16
    vecs.push_back(mk(0, 1, 32'h00400213, 1, 0, 32'h0,        0, 32'h200,      0, NOP,           32'hC));        // 17
    vecs.push_back(mk(0, 0, 32'h0,        0, 1, 32'hFFFFFFFC, 1, 32'h204,      1, 32'h00400213,  32'h200));      // 18 redirect in REQ
    vecs.push_back(mk(1, 0, 32'h0,        0, 0, 32'h0,        1, 32'hFFFFFFFC, 0, NOP,           32'h200));      // 19
    vecs.push_back(mk(0, 1, 32'h00000073, 0, 0, 32'h0,        0, 32'hFFFFFFFC, 0, NOP,           32'h200));      // 20
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h0,        1, 32'h00000073,  32'hFFFFFFFC)); // 21 wrap
    vecs.push_back(mk(1, 0, 32'h0,        0, 1, 32'h300,      1, 32'h0,        0, 32'h00000073,  32'hFFFFFFFC)); // 22 redirect on accept
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h300,      0, NOP,           32'hFFFFFFFC)); // 23 DROP waits
    vecs.push_back(mk(0, 1, 32'h00000BAD, 0, 0, 32'h0,        0, 32'h300,      0, NOP,           32'hFFFFFFFC)); // 24 DROP discards
    vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h300,      0, NOP,           32'hFFFFFFFC)); // 25

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all("reset", 1'b0, 32'h0, 1'b0, NOP, 32'h0);

    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rdy, vecs[i].rvalid, vecs[i].rdata, vecs[i].stall, vecs[i].redir, vecs[i].rpc);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_vld,
                vecs[i].e_ir, vecs[i].e_pc);
      @(posedge clk); #1;
    end

    // Reset asserted while a request is outstanding, then a late response after release.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check("wait imem_req", {31'd0, imem_req}, 32'd0);
    rst = 1'b1;
    #1;
    check_all("async rst", 1'b0, 32'h0, 1'b0, NOP, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, 1'b1, 32'hBADBAD00, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_all("post rst", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_all("late rvalid", 1'b1, 32'h0, 1'b0, NOP, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'h00A00513, 1'b0, 1'b0, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    check_all("refetch", 1'b1, 32'h4, 1'b1, 32'h00A00513, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, SHALL be the PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0013, SHALL be the IR value presented while IF_VALID=0 after reset or flush.
REQ-003 Clocking SHALL be one clock; reset SHALL be asynchronous and active-high.
REQ-004 CLK  in  1  the single clock; all state SHALL update on the rising edge.
REQ-005 RST  in  1  asynchronous, active-high reset.
REQ-006 IMEM_REQ  out  1  fetch request valid.
REQ-007 IMEM_ADDR  out  32  fetch address; word-aligned.
REQ-008 IMEM_RDY  in  1  memory accepts the request this cycle.
REQ-009 IMEM_RVALID  in  1  read data valid.
REQ-010 IMEM_RDATA  in  32  instruction word.
REQ-011 STALL  in  1  decode cannot consume; hold IF/ID.
REQ-012 REDIRECT  in  1  taken branch, jump or flush request.
REQ-013 REDIRECT_PC  in  32  redirect target.
REQ-014 IR  out  32  IF/ID instruction; drives decode OPCODE/FUNC3/FUNC7.
REQ-015 IF_PC  out  32  PC of IR.
REQ-016 IF_PC4  out  32  IF_PC+4, for the JAL/JALR link path.
REQ-017 IF_VALID  out  1  IR holds a live instruction.

Function
REQ-018 FSM states SHALL be REQ, WAIT, SKID and DROP, with at most one memory request outstanding.
REQ-019 IMEM_REQ SHALL be 1 only in REQ with RST=0; IMEM_ADDR SHALL equal PC.
REQ-020 Handshake: a request SHALL be accepted when IMEM_REQ=1 and IMEM_RDY=1, moving the FSM REQ->WAIT; IMEM_ADDR SHALL be held stable until acceptance.
REQ-021 IMEM_RVALID SHALL be honoured only in WAIT or DROP, with minimum latency one cycle after acceptance, and ignored in REQ or SKID.
REQ-022 "Accept" SHALL mean (STALL=0 or IF_VALID=0).
REQ-023 In WAIT with RVALID and accept: the block SHALL load IR=RDATA, IF_PC=PC, IF_VALID=1, set PC<=PC+4, and go to REQ, giving 1-cycle response-to-IR latency.
REQ-024 In WAIT with RVALID and no accept: RDATA and PC SHALL be captured in the skid register, PC<=PC+4, and the FSM SHALL go to SKID.
REQ-025 In SKID, when accept: the skid contents SHALL move to IF/ID with IF_VALID=1, and the FSM SHALL go to REQ; no request SHALL be issued while in SKID.
REQ-026 With STALL=1, IR, IF_PC and IF_VALID SHALL hold; with STALL=0 and no new word this cycle, IF_VALID SHALL go to 0 (bubble), and IR SHALL hold.
REQ-027 REDIRECT SHALL have highest priority: PC<={REDIRECT_PC[31:2],2'b00}, IF_VALID<=0, IR<=NOP_INSTR, skid invalidated, irrespective of STALL.
REQ-028 Redirect next state: WAIT->DROP; REQ with the request accepted the same cycle->DROP; DROP->DROP; otherwise ->REQ.
REQ-029 In DROP, RVALID data SHALL be discarded, IF/ID and PC SHALL be unchanged, and the FSM SHALL go to REQ.
REQ-030 PC arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC+4 = 32'h0000_0000; IF_PC4 SHALL wrap identically.
REQ-031 RVALID and REDIRECT in the same WAIT cycle SHALL result in the data being discarded and the FSM going to REQ with PC=target.

Reset
REQ-032 RST=1 SHALL immediately force PC=RESET_VECTOR, state=REQ, IR=NOP_INSTR, IF_PC=RESET_VECTOR, IF_VALID=0, skid empty, IMEM_REQ=0.
REQ-033 Reset asserted mid-request SHALL abandon it; an RVALID arriving after reset deasserts without an accepted request SHALL be ignored.
REQ-034 The first request SHALL issue in the first cycle with RST=0, at RESET_VECTOR.

Structure
REQ-035 The shared package SHALL hold the fetch state enum, NOP_INSTR and the default RESET_VECTOR.
REQ-036 The skid register SHALL be sub-module fetch_skid (32-bit data + 32-bit PC + valid, load/clear); the FSM, PC and IF/ID registers SHALL stay in if_stage.

Verification
REQ-037 Reset then RDY=1 and RVALID one cycle after each accept -> IMEM_ADDR 0,4,8; IR sequence matches memory; IF_PC4 = IF_PC+4.
REQ-038 STALL=1 while a fetch is in WAIT, response 32'h00500093 arrives -> SKID entered, IMEM_REQ=0, IF/ID held; STALL=0 -> IR=32'h00500093 the next cycle.
REQ-039 REDIRECT to 32'h0000_0102 while WAIT -> DROP, stale RVALID discarded, next IMEM_ADDR=32'h0000_0100, IF_VALID=0.
REQ-040 REDIRECT coincident with RVALID and STALL=1 -> IF_VALID=0, IR=NOP_INSTR, no instruction delivered, request at the target.
REQ-041 PC=32'hFFFF_FFFC fetched -> next IMEM_ADDR=0, IF_PC4=0.
REQ-042 RST asserted in WAIT, late RVALID after deassert -> ignored; first request at RESET_VECTOR.
